adc_fifo_byte_unpacker: RTL and testbench



---
 rtl/adc_fifo_byte_unpacker_if.sv | 29 ++
 rtl/adc_fifo_byte_unpacker.sv | 204 ++++++++++++++++++++
 tb/tb_adc_fifo_byte_unpacker.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_fifo_byte_unpacker_if.sv
// rtl/adc_fifo_byte_unpacker_if.sv - source FIFO read port and byte-stream head port
interface adc_fifo_byte_unpacker_if #(
    parameter int pSRC_WIDTH = 64
);
    logic                  src_empty;
    logic                  src_rd_en;
    logic [pSRC_WIDTH-1:0] src_data;
    logic                  fifo_empty;
    logic [7:0]            fifo_data;
    logic                  fifo_rd_en;

    modport slave (
        input  src_empty,
        input  src_data,
        input  fifo_rd_en,
        output src_rd_en,
        output fifo_empty,
        output fifo_data
    );

    modport master (
        output src_empty,
        output src_data,
        output fifo_rd_en,
        input  src_rd_en,
        input  fifo_empty,
        input  fifo_data
    );
endinterface

// File: rtl/adc_fifo_byte_unpacker.sv
// rtl/adc_fifo_byte_unpacker.sv - 64-bit FIFO word to FWFT byte stream with error bookkeeping
module adc_fifo_byte_unpacker #(
    parameter int pSRC_WIDTH     = 64,
    parameter int pUNDERFLOW_SAT = 255
) (
    input  logic                  clk_usb,
    input  logic                  reset,
    adc_fifo_byte_unpacker_if.slave bus,
    input  logic                  src_overflow,
    input  logic                  low_res,
    input  logic                  low_res_lsb,
    output logic [7:0]            fifo_error_stat,
    input  logic                  clear_fifo_errors,
    input  logic                  no_underflow_errors,
    output logic [7:0]            underflow_count,
    output logic [31:0]           fifo_read_count,
    output logic [31:0]           fifo_read_count_error_freeze,
    input  logic [16:0]           stream_segment_threshold,
    output logic                  segment_done
);

    logic [pSRC_WIDTH-1:0] cur_word_q, cur_word_d;
    logic [2:0]            cur_idx_q, cur_idx_d;
    logic                  cur_valid_q, cur_valid_d;
    logic                  cur_low_res_q, cur_low_res_d;
    logic                  cur_lsb_q, cur_lsb_d;
    logic [pSRC_WIDTH-1:0] nxt_word_q, nxt_word_d;
    logic                  nxt_valid_q, nxt_valid_d;
    logic                  rd_pend_q, rd_pend_d;
    logic                  fifo_empty_q, fifo_empty_d;
    logic [7:0]            fifo_data_q, fifo_data_d;
    logic [1:0]            err_q, err_d;
    logic [7:0]            underflow_count_q, underflow_count_d;
    logic [31:0]           read_count_q, read_count_d;
    logic [31:0]           freeze_q, freeze_d;
    logic [16:0]           seg_cnt_q, seg_cnt_d;
    logic                  seg_done_q, seg_done_d;

    logic       pop;
    logic       underflow;
    logic       uf_err;
    logic       cur_last;
    logic       cur_free;
    logic       nxt_moving;
    logic       src_to_cur;
    logic       src_rd_en;
    logic [2:0] last_idx;
    logic [16:0] seg_inc;

    // Low-res samples are packed five to a word in [59:0], sample 0 highest.
    function automatic logic [7:0] head_byte(
        input logic [pSRC_WIDTH-1:0] word,
        input logic [2:0]            idx,
        input logic                  lr,
        input logic                  lsb
    );
        logic [11:0] smp;
        logic [7:0]  b;
        smp = 12'h000;
        case (idx)
            3'd0:    smp = word[59:48];
            3'd1:    smp = word[47:36];
            3'd2:    smp = word[35:24];
            3'd3:    smp = word[23:12];
            default: smp = word[11:0];
        endcase
        if (lr) begin
            b = lsb ? smp[7:0] : smp[11:4];
        end else begin
            b = word[pSRC_WIDTH - 1 - 8 * int'(idx) -: 8];
        end
        return b;
    endfunction

    always_comb begin
        cur_word_d        = cur_word_q;
        cur_idx_d         = cur_idx_q;
        cur_valid_d       = cur_valid_q;
        cur_low_res_d     = cur_low_res_q;
        cur_lsb_d         = cur_lsb_q;
        nxt_word_d        = nxt_word_q;
        nxt_valid_d       = nxt_valid_q;
        err_d             = err_q;
        underflow_count_d = underflow_count_q;
        read_count_d      = read_count_q;
        freeze_d          = freeze_q;
        seg_cnt_d         = seg_cnt_q;
        seg_done_d        = 1'b0;
        seg_inc           = seg_cnt_q + 17'd1;

        last_idx   = cur_low_res_q ? 3'd4 : 3'd7;
        pop        = bus.fifo_rd_en && cur_valid_q;
        underflow  = bus.fifo_rd_en && !cur_valid_q;
        uf_err     = underflow && !no_underflow_errors;
        cur_last   = pop && (cur_idx_q == last_idx);
        cur_free   = !cur_valid_q || cur_last;
        nxt_moving = cur_free && nxt_valid_q;
        src_to_cur = cur_free && !nxt_valid_q && rd_pend_q;

        // Only one read outstanding, and only when a slot is guaranteed next cycle.
        src_rd_en = !reset && !bus.src_empty && !rd_pend_q && (!nxt_valid_q || nxt_moving);
        rd_pend_d = src_rd_en;

        if (pop) begin
            cur_idx_d = cur_idx_q + 3'd1;
        end
        if (cur_free) begin
            cur_valid_d = 1'b0;
        end
        if (nxt_moving || src_to_cur) begin
            cur_word_d    = nxt_moving ? nxt_word_q : bus.src_data;
            cur_idx_d     = 3'd0;
            cur_valid_d   = 1'b1;
            cur_low_res_d = low_res;
            cur_lsb_d     = low_res_lsb;
        end
        if (nxt_moving) begin
            nxt_valid_d = 1'b0;
        end
        if (rd_pend_q && !src_to_cur) begin
            nxt_word_d  = bus.src_data;
            nxt_valid_d = 1'b1;
        end

        fifo_empty_d = !cur_valid_d;
        fifo_data_d  = cur_valid_d ? head_byte(cur_word_d, cur_idx_d, cur_low_res_d, cur_lsb_d)
                                   : 8'h00;

        if (pop) begin
            read_count_d = read_count_q + 32'd1;
            if (stream_segment_threshold != 17'd0) begin
                if (seg_inc == stream_segment_threshold) begin
                    seg_cnt_d  = 17'd0;
                    seg_done_d = 1'b1;
                end else begin
                    seg_cnt_d = seg_inc;
                end
            end
        end

        if (underflow && (underflow_count_q != 8'(pUNDERFLOW_SAT))) begin
            underflow_count_d = underflow_count_q + 8'd1;
        end
        // Freeze uses the pre-increment count; a same-cycle clear overrides any event.
        if (clear_fifo_errors) begin
            err_d             = 2'b00;
            underflow_count_d = 8'd0;
            freeze_d          = 32'd0;
        end else begin
            if ((err_q == 2'b00) && (uf_err || src_overflow)) begin
                freeze_d = read_count_q;
            end
            err_d = err_q | {src_overflow, uf_err};
        end
    end

    always_ff @(posedge clk_usb) begin
        if (reset) begin
            cur_word_q        <= '0;
            cur_idx_q         <= 3'd0;
            cur_valid_q       <= 1'b0;
            cur_low_res_q     <= 1'b0;
            cur_lsb_q         <= 1'b0;
            nxt_word_q        <= '0;
            nxt_valid_q       <= 1'b0;
            rd_pend_q         <= 1'b0;
            fifo_empty_q      <= 1'b1;
            fifo_data_q       <= 8'h00;
            err_q             <= 2'b00;
            underflow_count_q <= 8'd0;
            read_count_q      <= 32'd0;
            freeze_q          <= 32'd0;
            seg_cnt_q         <= 17'd0;
            seg_done_q        <= 1'b0;
        end else begin
            cur_word_q        <= cur_word_d;
            cur_idx_q         <= cur_idx_d;
            cur_valid_q       <= cur_valid_d;
            cur_low_res_q     <= cur_low_res_d;
            cur_lsb_q         <= cur_lsb_d;
            nxt_word_q        <= nxt_word_d;
            nxt_valid_q       <= nxt_valid_d;
            rd_pend_q         <= rd_pend_d;
            fifo_empty_q      <= fifo_empty_d;
            fifo_data_q       <= fifo_data_d;
            err_q             <= err_d;
            underflow_count_q <= underflow_count_d;
            read_count_q      <= read_count_d;
            freeze_q          <= freeze_d;
            seg_cnt_q         <= seg_cnt_d;
            seg_done_q        <= seg_done_d;
        end
    end

    assign bus.src_rd_en               = src_rd_en;
    assign bus.fifo_empty              = fifo_empty_q;
    assign bus.fifo_data               = fifo_data_q;
    assign fifo_error_stat             = {6'b000000, err_q};
    assign underflow_count             = underflow_count_q;
    assign fifo_read_count             = read_count_q;
    assign fifo_read_count_error_freeze = freeze_q;
    assign segment_done                = seg_done_q;

endmodule

// File: tb/tb_adc_fifo_byte_unpacker.sv
// tb/tb_adc_fifo_byte_unpacker.sv - directed bench with byte-queue reference model
module tb_adc_fifo_byte_unpacker;

    logic        clk_usb = 1'b0;
    logic        reset = 1'b1;
    logic        src_overflow = 1'b0;
    logic        low_res = 1'b0;
    logic        low_res_lsb = 1'b0;
    logic        clear_fifo_errors = 1'b0;
    logic        no_underflow_errors = 1'b0;
    logic [16:0] stream_segment_threshold = 17'd0;
    logic [7:0]  fifo_error_stat;
    logic [7:0]  underflow_count;
    logic [31:0] fifo_read_count;
    logic [31:0] fifo_read_count_error_freeze;
    logic        segment_done;

    adc_fifo_byte_unpacker_if bus();

    adc_fifo_byte_unpacker dut (
        .clk_usb                      (clk_usb),
        .reset                        (reset),
        .bus                          (bus),
        .src_overflow                 (src_overflow),
        .low_res                      (low_res),
        .low_res_lsb                  (low_res_lsb),
        .fifo_error_stat              (fifo_error_stat),
        .clear_fifo_errors            (clear_fifo_errors),
        .no_underflow_errors          (no_underflow_errors),
        .underflow_count              (underflow_count),
        .fifo_read_count              (fifo_read_count),
        .fifo_read_count_error_freeze (fifo_read_count_error_freeze),
        .stream_segment_threshold     (stream_segment_threshold),
        .segment_done                 (segment_done)
    );

    always #10 clk_usb = ~clk_usb;

    int n_checks = 0;
    int n_pass = 0;

    logic [63:0] src_words[$];
    bit          src_lr[$];
    bit          src_lsb[$];
    logic [7:0]  exp_q[$];
    logic [63:0] src_hold = '0;
    bit          pop_pend = 1'b0;
    int          src_rd_cnt = 0;

    logic [31:0] m_read_cnt = '0;
    logic [31:0] m_freeze = '0;
    logic [7:0]  m_uf_cnt = '0;
    logic [1:0]  m_err = '0;
    logic [16:0] m_seg = '0;
    bit          m_seg_done = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic expand(input logic [63:0] w, input bit lr, input bit lsb);
        logic [11:0] s;
        if (!lr) begin
            for (int i = 0; i < 8; i++) exp_q.push_back(8'((w >> (56 - 8 * i)) & 64'hFF));
        end else begin
            for (int i = 0; i < 5; i++) begin
                s = 12'((w >> (48 - 12 * i)) & 64'hFFF);
                exp_q.push_back(lsb ? s[7:0] : s[11:4]);
            end
        end
    endtask

    // Source FIFO model plus per-cycle comparison against the byte-queue model.
    initial begin
        bit pop_m, uf_m, uf_err_m;
        bus.src_empty = 1'b1;
        bus.src_data  = '0;
        forever begin
            @(negedge clk_usb);
            #4;
            if (pop_pend) bus.src_data = src_hold;
            bus.src_empty = (src_words.size() == 0);
            #4;
            chk("mon_error_stat", fifo_error_stat, {6'b0, m_err});
            chk("mon_underflow_count", underflow_count, m_uf_cnt);
            chk("mon_read_count", fifo_read_count, m_read_cnt);
            chk("mon_freeze", fifo_read_count_error_freeze, m_freeze);
            chk("mon_segment_done", segment_done, m_seg_done);
            if (!bus.fifo_empty) begin
                chk("mon_byte_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) chk("mon_fifo_data", bus.fifo_data, exp_q[0]);
            end
            if (reset) begin
                exp_q.delete();
                m_read_cnt = '0; m_freeze = '0; m_uf_cnt = '0; m_err = '0;
                m_seg = '0; m_seg_done = 1'b0;
            end else begin
                pop_m    = bus.fifo_rd_en && !bus.fifo_empty;
                uf_m     = bus.fifo_rd_en && bus.fifo_empty;
                uf_err_m = uf_m && !no_underflow_errors;
                m_seg_done = 1'b0;
                if (uf_m && m_uf_cnt < 8'd255) m_uf_cnt++;
                if (clear_fifo_errors) begin
                    m_err = '0; m_uf_cnt = '0; m_freeze = '0;
                end else begin
                    if (m_err == 2'b00 && (uf_err_m || src_overflow)) m_freeze = m_read_cnt;
                    if (uf_err_m) m_err[0] = 1'b1;
                    if (src_overflow) m_err[1] = 1'b1;
                end
                if (pop_m) begin
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                    m_read_cnt++;
                    if (stream_segment_threshold != 0) begin
                        m_seg++;
                        if (m_seg == stream_segment_threshold) begin
                            m_seg_done = 1'b1;
                            m_seg = '0;
                        end
                    end
                end
            end
            pop_pend = bus.src_rd_en;
            if (bus.src_rd_en && src_words.size() != 0) begin
                src_rd_cnt++;
                src_hold = src_words.pop_front();
                expand(src_hold, src_lr.pop_front(), src_lsb.pop_front());
            end
        end
    end

    task automatic cyc();
        @(negedge clk_usb);
        #2;
    endtask

    task automatic push(input logic [63:0] w);
        src_words.push_back(w);
        src_lr.push_back(low_res);
        src_lsb.push_back(low_res_lsb);
    endtask

    task automatic wait_data(input string name);
        int n;
        n = 0;
        while (bus.fifo_empty && n < 20) begin
            cyc();
            n++;
        end
        chk({name, "_wait_empty"}, bus.fifo_empty, 1'b0);
    endtask

    task automatic pop_expect(input string name, input logic [7:0] b);
        chk({name, "_empty"}, bus.fifo_empty, 1'b0);
        chk(name, bus.fifo_data, b);
        bus.fifo_rd_en = 1'b1;
        cyc();
        bus.fifo_rd_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] w;
        logic [7:0]  lr0 [5];
        logic [7:0]  lr1 [5];
        int          r0;
        int          mask;
        bus.fifo_rd_en = 1'b0;
        lr0 = '{8'hAB, 8'h12, 8'hFF, 8'h00, 8'h80};
        lr1 = '{8'hBC, 8'h23, 8'hFF, 8'h00, 8'h01};

        repeat (3) cyc();
        reset = 1'b0;
        cyc();
        chk("rst_fifo_empty", bus.fifo_empty, 1'b1);
        chk("rst_fifo_data", bus.fifo_data, 8'h00);
        chk("rst_read_count", fifo_read_count, 32'd0);
        chk("rst_error_stat", fifo_error_stat, 8'h00);
        chk("rst_src_rd_en", bus.src_rd_en, 1'b0);

        // Normal mode with first-byte latency.
        push(64'h0011223344556677);
        #4;
        chk("lat_src_rd_en_c0", bus.src_rd_en, 1'b1);
        cyc();
        chk("lat_empty_c1", bus.fifo_empty, 1'b1);
        cyc();
        chk("lat_empty_c2", bus.fifo_empty, 1'b0);
        for (int i = 0; i < 8; i++) pop_expect("normal_byte", 8'(8'h11 * i));
        chk("normal_empty_after", bus.fifo_empty, 1'b1);
        chk("normal_read_count", fifo_read_count, 32'd8);

        // Low-resolution, both sample halves.
        low_res = 1'b1;
        low_res_lsb = 1'b0;
        push(64'h0ABC123FFF000801);
        wait_data("lr_msb");
        for (int i = 0; i < 5; i++) pop_expect("lr_msb_byte", lr0[i]);
        chk("lr_msb_empty_after", bus.fifo_empty, 1'b1);
        low_res_lsb = 1'b1;
        push(64'h0ABC123FFF000801);
        wait_data("lr_lsb");
        for (int i = 0; i < 5; i++) pop_expect("lr_lsb_byte", lr1[i]);
        chk("lr_lsb_empty_after", bus.fifo_empty, 1'b1);
        low_res = 1'b0;
        low_res_lsb = 1'b0;

        // Throughput: four words, 32 back-to-back pops.
        r0 = src_rd_cnt;
        for (int k = 0; k < 4; k++) begin
            w = '0;
            for (int j = 0; j < 8; j++) w = (w << 8) | 64'(8 * k + j);
            push(w);
        end
        wait_data("thru");
        for (int k = 0; k < 32; k++) pop_expect("thru_byte", 8'(k));
        chk("thru_src_reads", src_rd_cnt - r0, 4);
        chk("thru_empty_after", bus.fifo_empty, 1'b1);
        chk("thru_read_count", fifo_read_count, 32'd50);

        // Overflow sticky bit and freeze, then clear.
        src_overflow = 1'b1;
        cyc();
        src_overflow = 1'b0;
        chk("ovf_error_stat", fifo_error_stat, 8'h02);
        chk("ovf_freeze", fifo_read_count_error_freeze, 32'd50);
        clear_fifo_errors = 1'b1;
        cyc();
        clear_fifo_errors = 1'b0;
        chk("ovf_clear_stat", fifo_error_stat, 8'h00);
        chk("ovf_clear_freeze", fifo_read_count_error_freeze, 32'd0);

        // Underflow saturation.
        bus.fifo_rd_en = 1'b1;
        repeat (300) cyc();
        bus.fifo_rd_en = 1'b0;
        chk("uf_count_sat", underflow_count, 8'd255);
        chk("uf_error_stat", fifo_error_stat, 8'h01);
        chk("uf_freeze", fifo_read_count_error_freeze, 32'd50);
        chk("uf_read_count_kept", fifo_read_count, 32'd50);
        chk("uf_still_empty", bus.fifo_empty, 1'b1);
        clear_fifo_errors = 1'b1;
        cyc();
        clear_fifo_errors = 1'b0;
        chk("uf_clear_count", underflow_count, 8'd0);
        chk("uf_clear_stat", fifo_error_stat, 8'h00);
        chk("uf_clear_freeze", fifo_read_count_error_freeze, 32'd0);
        no_underflow_errors = 1'b1;
        bus.fifo_rd_en = 1'b1;
        repeat (10) cyc();
        bus.fifo_rd_en = 1'b0;
        no_underflow_errors = 1'b0;
        chk("uf_suppr_count", underflow_count, 8'd10);
        chk("uf_suppr_stat", fifo_error_stat, 8'h00);
        clear_fifo_errors = 1'b1;
        bus.fifo_rd_en = 1'b1;
        cyc();
        clear_fifo_errors = 1'b0;
        bus.fifo_rd_en = 1'b0;
        chk("clr_wins_count", underflow_count, 8'd0);
        chk("clr_wins_stat", fifo_error_stat, 8'h00);

        // Segments: threshold 5 over 12 pops, then disabled.
        stream_segment_threshold = 17'd5;
        push(64'h1011121314151617);
        push(64'h18191A1B1C1D1E1F);
        wait_data("seg");
        mask = 0;
        for (int p = 1; p <= 12; p++) begin
            pop_expect("seg_byte", 8'(8'h0F + p));
            if (segment_done) mask = mask | (1 << p);
        end
        chk("seg_pulse_mask", mask, (1 << 5) | (1 << 10));
        stream_segment_threshold = 17'd0;
        mask = 0;
        for (int p = 13; p <= 16; p++) begin
            pop_expect("seg0_byte", 8'(8'h0F + p));
            if (segment_done) mask = mask | (1 << p);
        end
        chk("seg0_no_pulse", mask, 0);
        chk("seg_read_count", fifo_read_count, 32'd66);

        // Reset mid-word with a source read in flight.
        push(64'hA0A1A2A3A4A5A6A7);
        wait_data("mid");
        for (int i = 0; i < 3; i++) pop_expect("mid_byte", 8'(8'hA0 + i));
        push(64'hB0B1B2B3B4B5B6B7);
        #4;
        chk("mid_inflight_rd", bus.src_rd_en, 1'b1);
        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("mid_rst_empty", bus.fifo_empty, 1'b1);
        chk("mid_rst_read_count", fifo_read_count, 32'd0);
        chk("mid_rst_uf_count", underflow_count, 8'd0);
        repeat (3) cyc();
        chk("mid_late_discarded", bus.fifo_empty, 1'b1);
        push(64'hC0C1C2C3C4C5C6C7);
        wait_data("fresh");
        for (int i = 0; i < 8; i++) pop_expect("fresh_byte", 8'(8'hC0 + i));
        chk("fresh_read_count", fifo_read_count, 32'd8);
        chk("fresh_empty_after", bus.fifo_empty, 1'b1);

        repeat (3) cyc();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
